cache_loader: RTL and testbench

CACHE_LOADER -- requirements
Module: cache_loader

---
 rtl/cache_loader.sv | 203 ++++++++++++++++++++
 tb/tb_cache_loader.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_loader.sv
// Serial loader for the instruction and data caches.
// Frames are shifted in on mosi_in, MSB first, one bit per clk.
module cache_loader (
  input  logic       clk,
  input  logic       rst,
  input  logic       csi_in,
  input  logic       csd_in,
  input  logic       mosi_in,
  input  logic       proc_en_in,
  input  logic [7:0] rd_data_in,
  output logic [3:0] addr_out,
  output logic [7:0] wdata_out,
  output logic       icache_wen_out,
  output logic       dcache_wen_out,
  output logic       rd_sel_out,
  output logic       miso_out,
  output logic       proc_hold_out,
  output logic       busy_out,
  output logic       frame_err_out
);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WADDR_DATA,
    RADDR,
    RDATA,
    COMMIT,
    ERRWAIT
  } state_e;

  localparam logic [3:0] LAST_BIT = 4'd13;
  localparam logic [3:0] RA_LAST  = 4'd4;
  localparam logic [3:0] D_NONE   = 4'd15;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [11:0] sr_q, sr_d;
  logic [7:0]  rd_sr_q, rd_sr_d;
  logic        cmd_q, cmd_d;
  logic        tgt_q, tgt_d;
  logic        iwen_q, iwen_d;
  logic        dwen_q, dwen_d;
  logic        err_q, err_d;
  logic [3:0]  caddr_q, caddr_d;
  logic [7:0]  cdata_q, cdata_d;

  logic       own_low;
  logic       oth_low;
  logic       both_low;
  logic       any_low;
  logic       fault;
  logic [3:0] cnt_inc;

  assign own_low  = tgt_q ? !csd_in : !csi_in;
  assign oth_low  = tgt_q ? !csi_in : !csd_in;
  assign both_low = !csi_in && !csd_in;
  assign any_low  = !csi_in || !csd_in;
  assign cnt_inc  = (cnt_q >= LAST_BIT) ? LAST_BIT
                                        : cnt_q + 4'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    rd_sr_d = rd_sr_q;
    cmd_d   = cmd_q;
    tgt_d   = tgt_q;
    iwen_d  = 1'b0;
    dwen_d  = 1'b0;
    err_d   = 1'b0;
    caddr_d = 4'd0;
    cdata_d = 8'd0;
    fault   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!proc_en_in) begin
          if (both_low) begin
            fault = 1'b1;
          end else if (any_low) begin
            cmd_d   = mosi_in;
            tgt_d   = !csd_in;
            cnt_d   = 4'd1;
            sr_d    = 12'd0;
            rd_sr_d = 8'd0;
            state_d = CMD;
          end
        end
      end

      CMD, WADDR_DATA, RADDR, RDATA: begin
        // oth_low covers both a collision and a target switch
        if (proc_en_in || oth_low) begin
          fault = 1'b1;
        end else if (!own_low) begin
          if (cnt_q != LAST_BIT) begin
            fault = 1'b1;
          end else if (state_q == RDATA) begin
            state_d = IDLE;
          end else if (state_q != WADDR_DATA) begin
            fault = 1'b1;
          end else if (tgt_q && sr_q[11:8] == D_NONE) begin
            fault = 1'b1;
          end else begin
            iwen_d  = !tgt_q;
            dwen_d  = tgt_q;
            caddr_d = sr_q[11:8];
            cdata_d = sr_q[7:0];
            state_d = COMMIT;
          end
        end else if (cnt_q == LAST_BIT) begin
          cnt_d = cnt_inc;
          fault = 1'b1;
        end else begin
          cnt_d = cnt_inc;
          if (state_q == RDATA) begin
            rd_sr_d = {rd_sr_q[6:0], 1'b0};
          end else begin
            sr_d = {sr_q[10:0], mosi_in};
          end
          if (state_q == CMD) begin
            state_d = cmd_q ? WADDR_DATA : RADDR;
          end else if (state_q == RADDR && cnt_q == RA_LAST) begin
            rd_sr_d = rd_data_in;
            state_d = RDATA;
          end
        end
      end

      COMMIT: begin
        state_d = IDLE;
      end

      ERRWAIT: begin
        if (csi_in && csd_in) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (fault) begin
      state_d = ERRWAIT;
      err_d   = 1'b1;
      iwen_d  = 1'b0;
      dwen_d  = 1'b0;
      caddr_d = 4'd0;
      cdata_d = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      sr_q    <= 12'd0;
      rd_sr_q <= 8'd0;
      cmd_q   <= 1'b0;
      tgt_q   <= 1'b0;
      iwen_q  <= 1'b0;
      dwen_q  <= 1'b0;
      err_q   <= 1'b0;
      caddr_q <= 4'd0;
      cdata_q <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      rd_sr_q <= rd_sr_d;
      cmd_q   <= cmd_d;
      tgt_q   <= tgt_d;
      iwen_q  <= iwen_d;
      dwen_q  <= dwen_d;
      err_q   <= err_d;
      caddr_q <= caddr_d;
      cdata_q <= cdata_d;
    end
  end

  // The final address bit is still on mosi_in when read data is captured.
  always_comb begin
    unique case (state_q)
      RADDR:   addr_out = {sr_q[2:0], mosi_in};
      RDATA:   addr_out = sr_q[3:0];
      default: addr_out = caddr_q;
    endcase
  end

  assign wdata_out      = cdata_q;
  assign icache_wen_out = iwen_q;
  assign dcache_wen_out = dwen_q;
  assign frame_err_out  = err_q;
  assign rd_sel_out     = tgt_q &&
                          (state_q == RADDR || state_q == RDATA);
  assign miso_out       = (state_q == RDATA) && rd_sr_q[7];
  assign proc_hold_out  = (state_q != IDLE) || !proc_en_in;
  assign busy_out       = (state_q != IDLE) && (state_q != ERRWAIT);

endmodule

// File: tb/tb_cache_loader.sv
// Directed bench for cache_loader: table of frames plus
// hand-written sequences for timing and error corners.
module tb_cache_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       csi;
  logic       csd;
  logic       mosi;
  logic       pen;
  logic [7:0] rd_data;
  logic [3:0] addr;
  logic [7:0] wdata;
  logic       iwen;
  logic       dwen;
  logic       rdsel;
  logic       miso;
  logic       hold;
  logic       busy;
  logic       ferr;

  always #5 clk = ~clk;

  cache_loader dut (
    .clk           (clk),
    .rst           (rst),
    .csi_in        (csi),
    .csd_in        (csd),
    .mosi_in       (mosi),
    .proc_en_in    (pen),
    .rd_data_in    (rd_data),
    .addr_out      (addr),
    .wdata_out     (wdata),
    .icache_wen_out(iwen),
    .dcache_wen_out(dwen),
    .rd_sel_out    (rdsel),
    .miso_out      (miso),
    .proc_hold_out (hold),
    .busy_out      (busy),
    .frame_err_out (ferr)
  );

  logic [7:0] imem [16];
  logic [7:0] dmem [16];

  assign rd_data = rdsel ? dmem[addr] : imem[addr];

  int checks   = 0;
  int failures = 0;

  int         iw_n;
  int         dw_n;
  int         er_n;
  int         both_n;
  logic [3:0] w_addr;
  logic [7:0] w_data;

  always @(negedge clk) begin
    if (iwen) iw_n++;
    if (dwen) dw_n++;
    if (ferr) er_n++;
    if (iwen && dwen) both_n++;
    if (iwen || dwen) begin
      w_addr = addr;
      w_data = wdata;
    end
  end

  typedef struct {
    logic        sel;
    int          n;
    logic [15:0] bits;
    int          iw;
    int          dw;
    int          er;
    logic [3:0]  a;
    logic [7:0]  d;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    iw_n   = 0;
    dw_n   = 0;
    er_n   = 0;
    both_n = 0;
    w_addr = 4'd0;
    w_data = 8'd0;
  endtask

  task automatic tick(input logic ci, input logic cd, input logic m);
    @(negedge clk);
    csi  = ci;
    csd  = cd;
    mosi = m;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic sel, input int n, input logic [15:0] bits);
    for (int i = n - 1; i >= 0; i--) begin
      tick(sel, !sel, bits[i]);
    end
  endtask

  task automatic end_frame();
    repeat (3) tick(1'b1, 1'b1, 1'b0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_iwen"}, int'(iwen), 0);
    chk({tag, "_dwen"}, int'(dwen), 0);
    chk({tag, "_ferr"}, int'(ferr), 0);
    chk({tag, "_miso"}, int'(miso), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_addr"}, int'(addr), 0);
    chk({tag, "_wdata"}, int'(wdata), 0);
    chk({tag, "_rdsel"}, int'(rdsel), 0);
    chk({tag, "_hold"}, int'(hold), 1);
  endtask

  logic [7:0] rd_exp;

  initial begin
    for (int i = 0; i < 16; i++) begin
      imem[i] = 8'hC0 | 8'(i);
      dmem[i] = 8'(i * 17);
    end
    dmem[7] = 8'h3C;

    tbl[0] = '{1'b0, 13, 16'h13A5, 1, 0, 0, 4'h3, 8'hA5};
    tbl[1] = '{1'b1, 13, 16'h153C, 0, 1, 0, 4'h5, 8'h3C};
    tbl[2] = '{1'b0,  9, 16'h013A, 0, 0, 1, 4'h0, 8'h00};
    tbl[3] = '{1'b1, 13, 16'h1F55, 0, 0, 1, 4'h0, 8'h00};
    tbl[4] = '{1'b0, 13, 16'h1FFF, 1, 0, 0, 4'hF, 8'hFF};
    tbl[5] = '{1'b0, 14, 16'h274B, 0, 0, 1, 4'h0, 8'h00};
    tbl[6] = '{1'b0, 13, 16'h0200, 0, 0, 0, 4'h0, 8'h00};
    tbl[7] = '{1'b1,  5, 16'h0007, 0, 0, 1, 4'h0, 8'h00};
    tbl[8] = '{1'b1,  1, 16'h0001, 0, 0, 1, 4'h0, 8'h00};
    tbl[9] = '{1'b1, 13, 16'h1EC3, 0, 1, 0, 4'hE, 8'hC3};

    rst  = 1'b1;
    csi  = 1'b1;
    csd  = 1'b1;
    mosi = 1'b0;
    pen  = 1'b0;
    clear_mon();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outs("reset");
    @(negedge clk);
    rst = 1'b0;
    end_frame();

    for (int v = 0; v < 10; v++) begin
      clear_mon();
      send(tbl[v].sel, tbl[v].n, tbl[v].bits);
      end_frame();
      chk($sformatf("v%0d_iwen", v), iw_n, tbl[v].iw);
      chk($sformatf("v%0d_dwen", v), dw_n, tbl[v].dw);
      chk($sformatf("v%0d_err", v), er_n, tbl[v].er);
      chk($sformatf("v%0d_both", v), both_n, 0);
      chk($sformatf("v%0d_busy", v), int'(busy), 0);
      if (tbl[v].iw + tbl[v].dw > 0) begin
        chk($sformatf("v%0d_addr", v), int'(w_addr), int'(tbl[v].a));
        chk($sformatf("v%0d_data", v), int'(w_data), int'(tbl[v].d));
      end
    end

    // icache write strobe lands one cycle after csi rises
    clear_mon();
    send(1'b0, 13, 16'h13A5);
    chk("wr_no_early_wen", iw_n, 0);
    chk("wr_busy_frame", int'(busy), 1);
    @(negedge clk);
    csi = 1'b1;
    @(posedge clk);
    #1;
    chk("wr_iwen", int'(iwen), 1);
    chk("wr_dwen", int'(dwen), 0);
    chk("wr_addr", int'(addr), 3);
    chk("wr_wdata", int'(wdata), 8'hA5);
    chk("wr_busy_commit", int'(busy), 1);
    tick(1'b1, 1'b1, 1'b0);
    chk("wr_iwen_off", int'(iwen), 0);
    chk("wr_busy_idle", int'(busy), 0);
    end_frame();
    chk("wr_iwen_once", iw_n, 1);

    // dcache readback of addr 7
    clear_mon();
    rd_exp = 8'h3C;
    tick(1'b1, 1'b0, 1'b0);
    chk("rd_miso_cmd", int'(miso), 0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b1);
    chk("rd_rdsel_addr", int'(rdsel), 1);
    tick(1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("rd_miso%0d", k), int'(miso), int'(rd_exp[7 - k]));
      chk($sformatf("rd_rdsel%0d", k), int'(rdsel), 1);
      tick(1'b1, 1'b0, 1'b0);
    end
    end_frame();
    chk("rd_err", er_n, 0);
    chk("rd_rdsel_idle", int'(rdsel), 0);
    chk("rd_miso_idle", int'(miso), 0);

    // collision holds the block in ERRWAIT
    clear_mon();
    tick(1'b0, 1'b0, 1'b1);
    chk("col_ferr", int'(ferr), 1);
    for (int k = 0; k < 4; k++) begin
      tick(1'b0, 1'b1, 1'b1);
      chk($sformatf("col_wait%0d", k), int'(busy), 0);
    end
    chk("col_ferr_off", int'(ferr), 0);
    end_frame();
    chk("col_err_once", er_n, 1);
    chk("col_nowen", iw_n + dw_n, 0);
    send(1'b0, 1, 16'h0001);
    chk("col_recover", int'(busy), 1);
    end_frame();

    // processor running: chip selects ignored
    clear_mon();
    pen = 1'b1;
    for (int k = 0; k < 13; k++) begin
      tick(1'(k % 2), 1'b1, 1'b1);
      chk($sformatf("pen_busy%0d", k), int'(busy), 0);
    end
    chk("pen_hold", int'(hold), 0);
    end_frame();
    chk("pen_nowen", iw_n + dw_n, 0);
    chk("pen_noerr", er_n, 0);

    // proc_en rising at bit 6 of a frame
    pen = 1'b0;
    #1;
    chk("pen_hold_back", int'(hold), 1);
    clear_mon();
    send(1'b0, 5, 16'h0013);
    @(negedge clk);
    csi  = 1'b0;
    mosi = 1'b1;
    pen  = 1'b1;
    @(posedge clk);
    #1;
    chk("pen_mid_ferr", int'(ferr), 1);
    pen = 1'b0;
    end_frame();
    chk("pen_mid_err_once", er_n, 1);
    chk("pen_mid_nowen", iw_n + dw_n, 0);

    // reset at bit 10 of a write frame
    clear_mon();
    send(1'b0, 10, 16'h0274);
    @(negedge clk);
    rst = 1'b1;
    csi = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_outs("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    end_frame();
    chk("rst_mid_nowen", iw_n + dw_n, 0);
    chk("rst_mid_noerr", er_n, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
